// File: rtl/fifo_sync_param_if.sv
// Bus bundle between the FIFO_in-side producer/consumer and fifo_sync_param.
// The master modport drives requests; the slave modport is the FIFO itself.
interface fifo_sync_param_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// synchronous flush and one-cycle overflow/underflow error pulses.
module fifo_sync_param #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input logic              clock,
   input logic              reset,
   fifo_sync_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]         wp_r;
   logic [AW-1:0]         rp_r;
   logic [CW-1:0]         count_r;
   logic [CW-1:0]         count_nxt_s;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;
   logic                  overflow_r;
   logic                  underflow_r;

   logic full_s;
   logic empty_s;
   logic wa_s;
   logic ra_s;

   // Flags decode the count register directly so they can never disagree with count.
   assign full_s  = (count_r == CW'(DEPTH));
   assign empty_s = (count_r == {CW{1'b0}});
   assign wa_s    = bus.wr_en & ~full_s;
   assign ra_s    = bus.rd_en & ~empty_s;

   assign bus.full         = full_s;
   assign bus.empty        = empty_s;
   assign bus.almost_full  = (count_r >= CW'(AF_THRESH));
   assign bus.almost_empty = (count_r <= CW'(AE_THRESH));
   assign bus.count        = count_r;
   assign bus.rd_data      = rd_data_r;
   assign bus.rd_valid     = rd_valid_r;
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;

   // Next occupancy: a simultaneous accepted write and read cancel out.
   always_comb begin
      count_nxt_s = count_r;
      case ({wa_s, ra_s})
         2'b10:   count_nxt_s = count_r + CW'(1'b1);
         2'b01:   count_nxt_s = count_r - CW'(1'b1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array; never cleared, only written by an accepted write.
   always_ff @(posedge clock) begin
      if (!reset && !bus.flush && wa_s) begin
         mem_r[wp_r] <= bus.wr_data;
      end
   end

   // Pointers, occupancy, read register and error pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         wp_r        <= {AW{1'b0}};
         rp_r        <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         rd_data_r   <= {DATA_WIDTH{1'b0}};
         rd_valid_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (bus.flush) begin
         // rd_data deliberately keeps its last value across a flush.
         wp_r        <= {AW{1'b0}};
         rp_r        <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         rd_valid_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wa_s) begin
            wp_r <= wp_r + AW'(1'b1);
         end
         if (ra_s) begin
            rp_r      <= rp_r + AW'(1'b1);
            rd_data_r <= mem_r[rp_r];
         end
         rd_valid_r  <= ra_s;
         count_r     <= count_nxt_s;
         overflow_r  <= bus.wr_en & full_s;
         underflow_r <= bus.rd_en & empty_s;
      end
   end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed table-driven bench for fifo_sync_param (DATA_WIDTH=8, DEPTH=4, AF=3, AE=1).
module tb_fifo_sync_param;
   localparam int DW = 8;
   localparam int DP = 4;
   localparam int CW = $clog2(DP) + 1;

   typedef struct {
      logic          rst;
      logic          fl;
      logic          wr;
      logic [DW-1:0] wd;
      logic          rd;
      logic [CW-1:0] cnt;
      logic          e;
      logic          f;
      logic          af;
      logic          ae;
      logic          rv;
      logic [DW-1:0] rdd;
      logic          chk;
      logic          ov;
      logic          uf;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   vec_t vec_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

   fifo_sync_param #(
      .DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(3), .AE_THRESH(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   function automatic void add(logic rst, logic fl, logic wr, logic [DW-1:0] wd, logic rd,
                               logic [CW-1:0] cnt, logic e, logic f, logic af, logic ae,
                               logic rv, logic [DW-1:0] rdd, logic chk, logic ov, logic uf);
      vec_t v;
      v = '{rst, fl, wr, wd, rd, cnt, e, f, af, ae, rv, rdd, chk, ov, uf};
      vec_q.push_back(v);
   endfunction

   task automatic drive(input logic rst, input logic fl, input logic wr,
                        input logic [DW-1:0] wd, input logic rd);
      @(negedge clock);
      reset       = rst;
      bus.flush   = fl;
      bus.wr_en   = wr;
      bus.wr_data = wd;
      bus.rd_en   = rd;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input vec_t v);
      logic [9:0] act;
      logic [9:0] exp;
      act = {bus.count, bus.empty, bus.full, bus.almost_full, bus.almost_empty,
             bus.rd_valid, bus.overflow, bus.underflow};
      exp = {v.cnt, v.e, v.f, v.af, v.ae, v.rv, v.ov, v.uf};
      n_vec++;
      if (act !== exp || (v.chk && bus.rd_data !== v.rdd)) begin
         n_err++;
         $display("FAIL %s: {count,e,f,af,ae,rv,ov,uf} got %b want %b, rd_data got %h want %h",
                  name, act, exp, bus.rd_data, v.rdd);
      end
   endtask

   initial begin
      vec_t hv;
      bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;

      // reset held two cycles
      add(1,0,0,8'h00,0, 3'd0,1,0,0,1, 0,8'h00,1, 0,0);
      add(1,0,0,8'h00,0, 3'd0,1,0,0,1, 0,8'h00,1, 0,0);
      // fill
      add(0,0,1,8'hA1,0, 3'd1,0,0,0,1, 0,8'h00,1, 0,0);
      add(0,0,1,8'hA2,0, 3'd2,0,0,0,0, 0,8'h00,1, 0,0);
      add(0,0,1,8'hA3,0, 3'd3,0,0,1,0, 0,8'h00,1, 0,0);
      add(0,0,1,8'hA4,0, 3'd4,0,1,1,0, 0,8'h00,1, 0,0);
      // overflow at full
      add(0,0,1,8'hFF,0, 3'd4,0,1,1,0, 0,8'h00,1, 1,0);
      add(0,0,0,8'h00,0, 3'd4,0,1,1,0, 0,8'h00,1, 0,0);
      // drain
      add(0,0,0,8'h00,1, 3'd3,0,0,1,0, 1,8'hA1,1, 0,0);
      add(0,0,0,8'h00,1, 3'd2,0,0,0,0, 1,8'hA2,1, 0,0);
      add(0,0,0,8'h00,1, 3'd1,0,0,0,1, 1,8'hA3,1, 0,0);
      add(0,0,0,8'h00,1, 3'd0,1,0,0,1, 1,8'hA4,1, 0,0);
      add(0,0,0,8'h00,0, 3'd0,1,0,0,1, 0,8'hA4,1, 0,0);
      // underflow at empty
      add(0,0,0,8'h00,1, 3'd0,1,0,0,1, 0,8'hA4,1, 0,1);
      add(0,0,0,8'h00,0, 3'd0,1,0,0,1, 0,8'hA4,1, 0,0);
      // simultaneous wr+rd at full
      add(0,0,1,8'hB1,0, 3'd1,0,0,0,1, 0,8'hA4,1, 0,0);
      add(0,0,1,8'hB2,0, 3'd2,0,0,0,0, 0,8'hA4,1, 0,0);
      add(0,0,1,8'hB3,0, 3'd3,0,0,1,0, 0,8'hA4,1, 0,0);
      add(0,0,1,8'hB4,0, 3'd4,0,1,1,0, 0,8'hA4,1, 0,0);
      add(0,0,1,8'hC5,1, 3'd3,0,0,1,0, 1,8'hB1,1, 1,0);
      add(0,0,0,8'h00,0, 3'd3,0,0,1,0, 0,8'hB1,1, 0,0);
      add(0,0,0,8'h00,1, 3'd2,0,0,0,0, 1,8'hB2,1, 0,0);
      add(0,0,0,8'h00,1, 3'd1,0,0,0,1, 1,8'hB3,1, 0,0);
      add(0,0,0,8'h00,1, 3'd0,1,0,0,1, 1,8'hB4,1, 0,0);
      // simultaneous wr+rd at empty
      add(0,0,1,8'hD1,1, 3'd1,0,0,0,1, 0,8'hB4,1, 0,1);
      add(0,0,1,8'hD2,0, 3'd2,0,0,0,0, 0,8'hB4,1, 0,0);
      // sustained wr+rd at count 2 across pointer wrap
      for (int i = 0; i < 10; i++) begin
         add(0,0,1,8'hE0 + 8'(i),1, 3'd2,0,0,0,0, 1,
             (i == 0) ? 8'hD1 : (i == 1) ? 8'hD2 : 8'hE0 + 8'(i - 2), 1, 0,0);
      end
      add(0,0,0,8'h00,1, 3'd1,0,0,0,1, 1,8'hE8,1, 0,0);
      add(0,0,0,8'h00,1, 3'd0,1,0,0,1, 1,8'hE9,1, 0,0);
      // flush mid-operation overrides wr and rd
      add(0,0,1,8'hF1,0, 3'd1,0,0,0,1, 0,8'hE9,1, 0,0);
      add(0,0,1,8'hF2,0, 3'd2,0,0,0,0, 0,8'hE9,1, 0,0);
      add(0,0,1,8'hF3,0, 3'd3,0,0,1,0, 0,8'hE9,1, 0,0);
      add(0,1,1,8'h77,1, 3'd0,1,0,0,1, 0,8'hE9,1, 0,0);
      add(0,0,1,8'h5A,0, 3'd1,0,0,0,1, 0,8'hE9,1, 0,0);
      add(0,0,0,8'h00,1, 3'd0,1,0,0,1, 1,8'h5A,1, 0,0);
      // reset mid-burst discards the read and clears rd_data
      add(0,0,1,8'h61,0, 3'd1,0,0,0,1, 0,8'h5A,1, 0,0);
      add(0,0,1,8'h62,0, 3'd2,0,0,0,0, 0,8'h5A,1, 0,0);
      add(1,0,1,8'h33,1, 3'd0,1,0,0,1, 0,8'h00,1, 0,0);

      for (int i = 0; i < vec_q.size(); i++) begin
         drive(vec_q[i].rst, vec_q[i].fl, vec_q[i].wr, vec_q[i].wd, vec_q[i].rd);
         check($sformatf("vec%0d", i), vec_q[i]);
      end

      // Held write at full: overflow each offending cycle, contents untouched.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h11 * 8'(i + 1), 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
         hv = '{0,0,0,8'h00,0, 3'd4,0,1,1,0, 0,8'h00,1, 1,0};
         check($sformatf("hold_ovf%0d", i), hv);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      hv = '{0,0,0,8'h00,0, 3'd4,0,1,1,0, 0,8'h00,1, 0,0};
      check("ovf_release", hv);
      // Back-to-back reads with no bubbles.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         hv = '{0,0,0,8'h00,1, 3'(3 - i), (i == 3), 0, (i == 0), (i >= 2),
                1, 8'h11 * 8'(i + 1), 1, 0, 0};
         check($sformatf("b2b_rd%0d", i), hv);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      hv = '{0,0,0,8'h00,0, 3'd0,1,0,0,1, 0,8'h44,1, 0,0};
      check("b2b_idle", hv);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
